// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: sequential Wishbone fetches buffered with their
// PCs in a small FIFO and handed to execute through a valid/ready handshake.
// Jumps flush the queue and redirect fetch; bus errors are tagged per entry
// and stop fetching until the next redirect.
module fetch_prefetch_queue #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] PC_RESET_VECTOR = '0,
  parameter int              QUEUE_DEPTH     = 4,
  parameter int              PC_STEP         = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           wb_cyc_o,
  output logic                           wb_stb_o,
  output logic                           wb_we_o,
  output logic [XLEN-1:0]                wb_adr_o,
  output logic [XLEN-1:0]                wb_dat_o,
  output logic [XLEN/8-1:0]              wb_sel_o,
  input  logic [XLEN-1:0]                wb_dat_i,
  input  logic                           wb_ack_i,
  input  logic                           wb_err_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [XLEN-1:0]                ir_o,
  output logic [XLEN-1:0]                pc_o,
  output logic                           fault_o,
  input  logic                           jump,
  input  logic [XLEN-1:0]                jump_target,
  output logic [$clog2(QUEUE_DEPTH):0]   count_o
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, HALT} state_t;

  state_t          state;
  logic [XLEN-1:0] fpc;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic [XLEN-1:0] q_pc    [QUEUE_DEPTH];
  logic [XLEN-1:0] q_ir    [QUEUE_DEPTH];
  logic            q_fault [QUEUE_DEPTH];

  logic            pop;
  logic            push;
  logic            can_req;
  logic [XLEN-1:0] jump_pc;
  logic [XLEN-1:0] next_fpc;

  // Read-only master: these never change.
  assign wb_we_o  = 1'b0;
  assign wb_dat_o = '0;
  assign wb_sel_o = '1;

  assign valid_o  = (count != '0);
  assign count_o  = count;
  assign ir_o     = q_ir[rd_ptr];
  assign pc_o     = q_pc[rd_ptr];
  // Gate the unreset fault bit so an empty queue never reports a fault.
  assign fault_o  = valid_o & q_fault[rd_ptr];

  assign pop      = valid_o && ready_i;
  // A jump or reset in the termination cycle discards the returned word.
  assign push     = (state == REQ) && (wb_ack_i || wb_err_i) && !jump && !rst;
  // A pop in the same cycle frees a slot, so a full queue can restart at once.
  assign can_req  = (count < CW'(QUEUE_DEPTH)) || pop;
  assign jump_pc  = jump_target & ~XLEN'(3);
  assign next_fpc = fpc + XLEN'(PC_STEP);

  // Fetch FSM, bus outputs and queue bookkeeping; jump outranks everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_adr_o <= PC_RESET_VECTOR;
      fpc      <= PC_RESET_VECTOR;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (jump) begin
      state    <= IDLE;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_adr_o <= jump_pc;
      fpc      <= jump_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (can_req) begin
            state    <= REQ;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_adr_o <= fpc;
          end
        end
        REQ: begin
          // ERR wins over a simultaneous ACK.
          if (wb_err_i) begin
            state    <= HALT;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
          end else if (wb_ack_i) begin
            state    <= IDLE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_adr_o <= next_fpc;
            fpc      <= next_fpc;
          end
        end
        HALT: begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
        end
      endcase

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage; only the pointers are reset, so the payload needs none.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= fpc;
      q_ir[wr_ptr]    <= wb_err_i ? '0 : wb_dat_i;
      q_fault[wr_ptr] <= wb_err_i;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: Wishbone slave model with programmable wait
// states and error address, a scoreboard of bus-returned words checked at every
// pop, a cycle table for the streaming case and hand-written corner sequences.
module tb_fetch_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;
  logic        valid_o, ready_i;
  logic [31:0] ir_o, pc_o;
  logic        fault_o;
  logic        jump;
  logic [31:0] jump_target;
  logic [2:0]  count_o;

  fetch_prefetch_queue dut (
    .clk(clk), .rst(rst),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .valid_o(valid_o), .ready_i(ready_i), .ir_o(ir_o), .pc_o(pc_o),
    .fault_o(fault_o), .jump(jump), .jump_target(jump_target),
    .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: mem[a] = a + 0x1000, nwait wait states, optional error address.
  int          nwait;
  int          wcnt;
  logic        err_en;
  logic [31:0] err_adr;

  assign wb_dat_i = wb_adr_o + 32'h1000;
  assign wb_ack_i = wb_cyc_o && wb_stb_o && (wcnt == nwait);
  assign wb_err_i = wb_ack_i && err_en && (wb_adr_o == err_adr);

  always @(posedge clk) begin
    if (!(wb_cyc_o && wb_stb_o) || wb_ack_i) wcnt <= 0;
    else                                     wcnt <= wcnt + 1;
  end

  int n_chk;
  int n_pass;
  int ack_cnt;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        fault;
  } ent_t;

  ent_t sb[$];

  // Scoreboard: record every terminated transfer, compare at every pop.
  always @(negedge clk) begin
    if (rst || jump) begin
      sb.delete();
    end else begin
      if (valid_o && ready_i) begin
        check("pop_has_expected_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          check("pop_pc", pc_o, sb[0].pc);
          check("pop_ir", ir_o, sb[0].ir);
          check("pop_fault", 32'(fault_o), 32'(sb[0].fault));
          void'(sb.pop_front());
        end
      end
      if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i)) begin
        ack_cnt++;
        sb.push_back('{wb_adr_o, wb_err_i ? 32'h0 : wb_dat_i, wb_err_i});
      end
    end
  end

  typedef struct {
    logic        ready;
    logic        cyc;
    logic [31:0] adr;
    logic        valid;
    logic [2:0]  count;
    logic [31:0] pc;
    logic [31:0] ir;
  } vec_t;

  vec_t tab[9];

  task automatic do_reset();
    rst = 1'b1;
    jump = 1'b0;
    ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ack_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic quiet;
    n_chk = 0; n_pass = 0; ack_cnt = 0;
    nwait = 0; err_en = 1'b0; err_adr = 32'h0;
    jump = 1'b0; jump_target = 32'h0; ready_i = 1'b0; rst = 1'b1;

    // Streaming with a zero-wait slave and an always-ready consumer.
    tab[0] = '{1'b1, 1'b0, 32'd0,  1'b0, 3'd0, 32'd0,  32'h0};
    tab[1] = '{1'b1, 1'b1, 32'd0,  1'b0, 3'd0, 32'd0,  32'h0};
    tab[2] = '{1'b1, 1'b0, 32'd4,  1'b1, 3'd1, 32'd0,  32'h1000};
    tab[3] = '{1'b1, 1'b1, 32'd4,  1'b0, 3'd0, 32'd0,  32'h0};
    tab[4] = '{1'b1, 1'b0, 32'd8,  1'b1, 3'd1, 32'd4,  32'h1004};
    tab[5] = '{1'b1, 1'b1, 32'd8,  1'b0, 3'd0, 32'd0,  32'h0};
    tab[6] = '{1'b1, 1'b0, 32'd12, 1'b1, 3'd1, 32'd8,  32'h1008};
    tab[7] = '{1'b1, 1'b1, 32'd12, 1'b0, 3'd0, 32'd0,  32'h0};
    tab[8] = '{1'b1, 1'b0, 32'd16, 1'b1, 3'd1, 32'd12, 32'h100c};

    // Reset values while reset is held.
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_stb", 32'(wb_stb_o), 32'd0);
    check("rst_adr", wb_adr_o, 32'h0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_fault", 32'(fault_o), 32'd0);
    check("const_we", 32'(wb_we_o), 32'd0);
    check("const_sel", 32'(wb_sel_o), 32'hf);
    check("const_dat", wb_dat_o, 32'h0);

    do_reset();
    for (int i = 0; i < 9; i++) begin
      ready_i = tab[i].ready;
      @(negedge clk);
      check($sformatf("tab%0d_cyc", i), 32'(wb_cyc_o), 32'(tab[i].cyc));
      check($sformatf("tab%0d_stb", i), 32'(wb_stb_o), 32'(tab[i].cyc));
      check($sformatf("tab%0d_adr", i), wb_adr_o, tab[i].adr);
      check($sformatf("tab%0d_valid", i), 32'(valid_o), 32'(tab[i].valid));
      check($sformatf("tab%0d_count", i), 32'(count_o), 32'(tab[i].count));
      if (tab[i].valid) begin
        check($sformatf("tab%0d_pc", i), pc_o, tab[i].pc);
        check($sformatf("tab%0d_ir", i), ir_o, tab[i].ir);
      end
      step();
    end

    // Fill with a stalled consumer, then one pop restarts fetch immediately.
    do_reset();
    repeat (14) step();
    @(negedge clk);
    check("full_transfers", 32'(ack_cnt), 32'd4);
    check("full_count", 32'(count_o), 32'd4);
    check("full_cyc_low", 32'(wb_cyc_o), 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wb_cyc_o) quiet = 1'b0;
    end
    check("full_stays_quiet", 32'(quiet), 32'd1);
    step();
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    @(negedge clk);
    check("full_pop_restart_cyc", 32'(wb_cyc_o), 32'd1);
    check("full_pop_restart_adr", wb_adr_o, 32'd16);
    check("full_pop_count", 32'(count_o), 32'd3);
    step();
    ready_i = 1'b1;
    repeat (12) step();
    ready_i = 1'b0;

    // Jump aborts a pending request held by wait states.
    do_reset();
    nwait = 3;
    for (int i = 0; i < 60; i++) begin
      if (wb_cyc_o && wb_adr_o == 32'd8) break;
      step();
    end
    check("wait_req_at_8", 32'(wb_cyc_o && wb_adr_o == 32'd8), 32'd1);
    jump = 1'b1;
    jump_target = 32'h203;
    step();
    jump = 1'b0;
    @(negedge clk);
    check("jabort_cyc_low", 32'(wb_cyc_o), 32'd0);
    check("jabort_count", 32'(count_o), 32'd0);
    check("jabort_valid", 32'(valid_o), 32'd0);
    step();
    @(negedge clk);
    check("jabort_new_cyc", 32'(wb_cyc_o), 32'd1);
    check("jabort_new_adr", wb_adr_o, 32'h200);
    step();
    ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_o) break;
    end
    check("jabort_first_pc", pc_o, 32'h200);
    step();
    ready_i = 1'b0;
    nwait = 0;

    // Jump in the same cycle as the ACK for address 4 discards that word.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (wb_cyc_o && wb_adr_o == 32'd4) break;
      step();
    end
    check("jack_req_at_4", 32'(wb_cyc_o && wb_ack_i && wb_adr_o == 32'd4), 32'd1);
    jump = 1'b1;
    jump_target = 32'h400;
    step();
    jump = 1'b0;
    @(negedge clk);
    check("jack_valid", 32'(valid_o), 32'd0);
    check("jack_count", 32'(count_o), 32'd0);
    step();
    ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_o) break;
    end
    check("jack_first_pc", pc_o, 32'h400);
    repeat (6) step();
    ready_i = 1'b0;

    // ERR (with ACK also raised) at address 8 halts fetch until a jump.
    do_reset();
    err_en = 1'b1;
    err_adr = 32'd8;
    repeat (10) step();
    @(negedge clk);
    check("err_count", 32'(count_o), 32'd3);
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb_cyc_o || wb_stb_o) quiet = 1'b0;
    end
    check("err_halt_quiet", 32'(quiet), 32'd1);
    step();
    ready_i = 1'b1;
    @(negedge clk);
    check("err_head0_fault", 32'(fault_o), 32'd0);
    step();
    @(negedge clk);
    check("err_head1_pc", pc_o, 32'd4);
    step();
    @(negedge clk);
    check("err_head2_pc", pc_o, 32'd8);
    check("err_head2_fault", 32'(fault_o), 32'd1);
    check("err_head2_ir", ir_o, 32'h0);
    step();
    ready_i = 1'b0;
    err_en = 1'b0;
    jump = 1'b1;
    jump_target = 32'h40;
    step();
    jump = 1'b0;
    @(negedge clk);
    check("err_jump_cyc_low", 32'(wb_cyc_o), 32'd0);
    step();
    @(negedge clk);
    check("err_resume_cyc", 32'(wb_cyc_o), 32'd1);
    check("err_resume_adr", wb_adr_o, 32'h40);
    step();
    ready_i = 1'b1;
    repeat (6) step();
    ready_i = 1'b0;

    // Reset while a request is pending with three entries queued.
    do_reset();
    nwait = 3;
    for (int i = 0; i < 100; i++) begin
      if (count_o == 3'd4) break;
      step();
    end
    check("rmid_fill", 32'(count_o), 32'd4);
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (wb_cyc_o && wb_adr_o == 32'h10) break;
      step();
    end
    check("rmid_req_at_10", 32'(wb_cyc_o && wb_adr_o == 32'h10), 32'd1);
    check("rmid_count3", 32'(count_o), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rmid_cyc", 32'(wb_cyc_o), 32'd0);
    check("rmid_count", 32'(count_o), 32'd0);
    check("rmid_valid", 32'(valid_o), 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (wb_cyc_o) break;
      step();
    end
    check("rmid_next_adr", wb_adr_o, 32'h0);
    check("rmid_next_cyc", 32'(wb_cyc_o), 32'd1);
    nwait = 0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
